// File: rtl/cpu_sequencer.sv
// Microcoded control sequencer for the cdecv 8-bit CPU: fetch, decode and execute
// of MOV/ALU/LD/ST/JP/HALT with optional memory wait states and an illegal-opcode trap.
module cpu_sequencer #(
   parameter int unsigned MEM_WAIT = 0,
   parameter bit          TRAP_EN  = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] I,
   input  logic [2:0] SZCy,
   input  logic       resume,
   output logic [2:0] xsrc,
   output logic [9:0] xdst,
   output logic [4:0] aluop,
   output logic       we,
   output logic       end_sq,
   output logic       halt,
   output logic       trap,
   output logic [4:0] state_out
);

   localparam bit         HasWait  = (MEM_WAIT != 0);
   localparam logic [3:0] WaitLoad = 4'(MEM_WAIT);

   localparam logic [2:0] SrcPc = 3'd0;
   localparam logic [2:0] SrcRd = 3'd4;

   localparam logic [9:0] DstPc = 10'h001;
   localparam logic [9:0] DstMa = 10'h010;
   localparam logic [9:0] DstWd = 10'h020;
   localparam logic [9:0] DstI  = 10'h040;
   localparam logic [9:0] DstT  = 10'h080;
   localparam logic [9:0] DstFlg = 10'h200;

   localparam logic [4:0] AluThru = 5'd0;
   localparam logic [4:0] AluInc  = 5'd1;

   typedef enum logic [4:0] {
      StR    = 5'd0,
      StF0   = 5'd1,
      StF1   = 5'd2,
      StFw   = 5'd3,
      StF2   = 5'd4,
      StMov0 = 5'd5,
      StAl0  = 5'd6,
      StAl1  = 5'd7,
      StLd0  = 5'd8,
      StLd1  = 5'd9,
      StLd2  = 5'd10,
      StLd3  = 5'd11,
      StLw   = 5'd12,
      StSt0  = 5'd13,
      StSt1  = 5'd14,
      StSt2  = 5'd15,
      StSt3  = 5'd16,
      StSt4  = 5'd17,
      StSw   = 5'd18,
      StJp0  = 5'd19,
      StJp1  = 5'd20,
      StJp2  = 5'd21,
      StJw   = 5'd22,
      StHalt = 5'd30,
      StTrap = 5'd31
   } state_e;

   state_e     state_q, state_d;
   state_e     ret_q, ret_d;
   logic [3:0] cnt_q, cnt_d;

   logic [1:0] src_code, dst_code, op_code;
   logic [2:0] cond_code;

   assign src_code  = I[3:2];
   assign dst_code  = I[1:0];
   assign op_code   = I[5:4];
   assign cond_code = I[2:0];

   function automatic logic [2:0] reg_src(input logic [1:0] r);
      case (r)
         2'd0:    return 3'd1;
         2'd1:    return 3'd2;
         2'd2:    return 3'd3;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic [9:0] reg_dst(input logic [1:0] r);
      case (r)
         2'd0:    return 10'h002;
         2'd1:    return 10'h004;
         2'd2:    return 10'h008;
         default: return 10'h000;
      endcase
   endfunction

   function automatic logic cond_met(input logic [2:0] c, input logic [2:0] f);
      case (c)
         3'd0:    return 1'b1;
         3'd1:    return f[1];
         3'd2:    return !f[1];
         3'd3:    return f[0];
         3'd4:    return !f[0];
         3'd5:    return f[2];
         3'd6:    return !f[2];
         default: return 1'b0;
      endcase
   endfunction

   function automatic state_e decode(input logic [7:0] ins);
      state_e bad;
      bad = TRAP_EN ? StTrap : StF0;
      if (ins[7:4] == 4'b0000) begin
         return (ins[3:2] != 2'd3 && ins[1:0] != 2'd3) ? StMov0 : bad;
      end else if (ins[7:6] == 2'b01) begin
         return (ins[3:2] != 2'd3 && ins[1:0] != 2'd3) ? StAl0 : bad;
      end else if (ins[7:2] == 6'b100000) begin
         return (ins[1:0] != 2'd3) ? StLd0 : bad;
      end else if (ins[7:4] == 4'b1010 && ins[1:0] == 2'b00) begin
         return (ins[3:2] != 2'd3) ? StSt0 : bad;
      end else if (ins[7:3] == 5'b11000) begin
         return (ins[2:0] != 3'b111) ? StJp0 : bad;
      end else if (ins == 8'hFF) begin
         return StHalt;
      end
      return bad;
   endfunction

   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StR;
         ret_q   <= StR;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         cnt_q   <= cnt_d;
      end
   end

   // Every wait state shares one counter; ret_q says where to go when it expires.
   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StR:  state_d = StF0;
         StF0: state_d = StF1;
         StF1: begin
            if (HasWait) begin
               state_d = StFw;
               cnt_d   = WaitLoad;
               ret_d   = StF2;
            end else begin
               state_d = StF2;
            end
         end
         StF2:   state_d = decode(I);
         StMov0: state_d = StF0;
         StAl0:  state_d = StAl1;
         StAl1:  state_d = StF0;
         StLd0:  state_d = StLd1;
         StLd1: begin
            if (HasWait) begin
               state_d = StLw;
               cnt_d   = WaitLoad;
               ret_d   = StLd2;
            end else begin
               state_d = StLd2;
            end
         end
         StLd2: begin
            if (HasWait) begin
               state_d = StLw;
               cnt_d   = WaitLoad;
               ret_d   = StLd3;
            end else begin
               state_d = StLd3;
            end
         end
         StLd3: state_d = StF0;
         StSt0: state_d = StSt1;
         StSt1: begin
            if (HasWait) begin
               state_d = StSw;
               cnt_d   = WaitLoad;
               ret_d   = StSt2;
            end else begin
               state_d = StSt2;
            end
         end
         StSt2: state_d = StSt3;
         StSt3: state_d = StSt4;
         StSt4: state_d = StF0;
         StJp0: state_d = StJp1;
         StJp1: begin
            if (HasWait) begin
               state_d = StJw;
               cnt_d   = WaitLoad;
               ret_d   = StJp2;
            end else begin
               state_d = StJp2;
            end
         end
         StJp2: state_d = StF0;
         StFw, StLw, StSw, StJw: begin
            if (cnt_q <= 4'd1) begin
               state_d = ret_q;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StHalt: state_d = resume ? StF0 : StHalt;
         StTrap: state_d = StTrap;
         default: state_d = StR;
      endcase
   end

   always_comb begin
      xsrc   = SrcPc;
      xdst   = 10'h000;
      aluop  = AluThru;
      we     = 1'b0;
      end_sq = 1'b0;
      halt   = 1'b0;
      trap   = 1'b0;
      unique case (state_q)
         StF0, StLd0, StSt0, StJp0: xdst = DstMa;
         StF1, StLd1, StSt1, StJp1: begin
            aluop = AluInc;
            xdst  = DstPc;
         end
         StF2: begin
            xsrc = SrcRd;
            xdst = DstI;
         end
         StMov0: begin
            xsrc   = reg_src(src_code);
            xdst   = reg_dst(dst_code);
            end_sq = 1'b1;
         end
         StAl0: begin
            xsrc = reg_src(dst_code);
            xdst = DstT;
         end
         StAl1: begin
            xsrc   = reg_src(src_code);
            aluop  = {3'b000, op_code} + 5'd2;
            xdst   = reg_dst(dst_code) | DstFlg;
            end_sq = 1'b1;
         end
         StLd2, StSt2: begin
            xsrc = SrcRd;
            xdst = DstMa;
         end
         StLd3: begin
            xsrc   = SrcRd;
            xdst   = reg_dst(dst_code);
            end_sq = 1'b1;
         end
         StSt3: begin
            xsrc = reg_src(src_code);
            xdst = DstWd;
         end
         StSt4: begin
            we     = 1'b1;
            end_sq = 1'b1;
         end
         StJp2: begin
            if (cond_met(cond_code, SZCy)) begin
               xsrc = SrcRd;
               xdst = DstPc;
            end
            end_sq = 1'b1;
         end
         StHalt: halt = 1'b1;
         StTrap: trap = 1'b1;
         default: ;
      endcase
   end

   assign state_out = state_q;

endmodule
